// File: rtl/wb_stage_if.sv
// MEM-stage handshake and data-memory response bundle feeding wb_stage.
interface wb_stage_if #(
    parameter int XLEN = 64,
    parameter int PC_W = 64
);
    logic            m_valid;
    logic            m_ready;
    logic [PC_W-1:0] m_pc;
    logic [4:0]      m_rd;
    logic            m_rd_we;
    logic [XLEN-1:0] m_result;
    logic            m_is_load;
    logic [2:0]      m_funct3;
    logic [2:0]      m_addr_lo;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    // Upstream side: MEM stage plus data memory.
    modport master (
        output m_valid, m_pc, m_rd, m_rd_we, m_result, m_is_load,
               m_funct3, m_addr_lo, dmem_rvalid, dmem_rdata,
        input  m_ready
    );

    // Writeback stage side.
    modport slave (
        input  m_valid, m_pc, m_rd, m_rd_we, m_result, m_is_load,
               m_funct3, m_addr_lo, dmem_rvalid, dmem_rdata,
        output m_ready
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage of the RV64 pipeline: accepts one retiring instruction,
// waits for load data when needed, aligns/extends it and drives the
// register-file write port plus a difftest commit pulse.
// Optional macro WB_COMMIT_CNT_EN enables the retired-instruction counter;
// when undefined commit_cnt is tied to zero.
module wb_stage #(
    parameter int XLEN = 64,
    parameter int PC_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    wb_stage_if.slave       mem,
    output logic [4:0]      WriteAddr,
    output logic [XLEN-1:0] WriteData,
    output logic            WriteEnable,
    output logic            stallW,
    output logic            wb_valid,
    output logic [PC_W-1:0] wb_pc,
    output logic [63:0]     commit_cnt
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [4:0]      r_rd;
    logic            r_rd_we;
    logic [2:0]      r_funct3;
    logic [2:0]      r_addr_lo;

    logic [4:0]      r_waddr;
    logic [XLEN-1:0] r_wdata;
    logic            r_we;
    logic            r_wb_valid;
    logic [PC_W-1:0] r_wb_pc;

    logic [XLEN-1:0] w_shifted;
    logic [XLEN-1:0] w_load_value;
    logic            w_accept;

    assign mem.m_ready = (r_state != S_WAIT);
    assign stallW      = (r_state == S_WAIT);
    assign w_accept    = mem.m_valid & (r_state != S_WAIT);

    assign WriteAddr   = r_waddr;
    assign WriteData   = r_wdata;
    assign WriteEnable = r_we;
    assign wb_valid    = r_wb_valid;
    assign wb_pc       = r_wb_pc;

    // Align the raw doubleword to the captured byte offset and extend per load type.
    always_comb begin
        w_shifted    = mem.dmem_rdata >> {r_addr_lo, 3'b000};
        w_load_value = '0;
        case (r_funct3)
            3'b000:  w_load_value = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            3'b001:  w_load_value = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load_value = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            3'b011:  w_load_value = w_shifted;
            3'b100:  w_load_value = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
            3'b101:  w_load_value = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            3'b110:  w_load_value = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
            default: w_load_value = '0;
        endcase
    end

    // Control FSM; commit outputs are loaded on the edge that enters COMMIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_rd       <= '0;
            r_rd_we    <= 1'b0;
            r_funct3   <= '0;
            r_addr_lo  <= '0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_pc    <= '0;
        end else begin
            r_we       <= 1'b0;
            r_wb_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_COMMIT: begin
                    if (w_accept) begin
                        r_pc      <= mem.m_pc;
                        r_rd      <= mem.m_rd;
                        r_rd_we   <= mem.m_rd_we;
                        r_funct3  <= mem.m_funct3;
                        r_addr_lo <= mem.m_addr_lo;
                        if (mem.m_is_load) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_state    <= S_COMMIT;
                            r_waddr    <= mem.m_rd;
                            r_wdata    <= mem.m_result;
                            r_we       <= mem.m_rd_we & (mem.m_rd != 5'd0);
                            r_wb_valid <= 1'b1;
                            r_wb_pc    <= mem.m_pc;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (mem.dmem_rvalid) begin
                        r_state    <= S_COMMIT;
                        r_waddr    <= r_rd;
                        r_wdata    <= w_load_value;
                        r_we       <= r_rd_we & (r_rd != 5'd0);
                        r_wb_valid <= 1'b1;
                        r_wb_pc    <= r_pc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef WB_COMMIT_CNT_EN
    logic [63:0] r_commit_cnt;

    // Count every commit cycle; wraps naturally at 64 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_commit_cnt <= '0;
        end else if (r_wb_valid) begin
            r_commit_cnt <= r_commit_cnt + 64'd1;
        end
    end

    assign commit_cnt = r_commit_cnt;
`else
    assign commit_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed, table-driven bench for wb_stage.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic [4:0]  WriteAddr;
    logic [63:0] WriteData;
    logic        WriteEnable;
    logic        stallW;
    logic        wb_valid;
    logic [63:0] wb_pc;
    logic [63:0] commit_cnt;

    int n_checks;
    int n_errors;
    logic [63:0] exp_cnt;

    wb_stage_if u_if ();

    wb_stage u_dut (
        .clk         (clk),
        .rst         (rst),
        .mem         (u_if.slave),
        .WriteAddr   (WriteAddr),
        .WriteData   (WriteData),
        .WriteEnable (WriteEnable),
        .stallW      (stallW),
        .wb_valid    (wb_valid),
        .wb_pc       (wb_pc),
        .commit_cnt  (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic [2:0]  f3;
        logic [2:0]  alo;
        logic [63:0] rdata;
        int unsigned delay;
        logic [4:0]  rd;
        logic        rd_we;
        logic [63:0] result;
        logic [63:0] pc;
        logic [63:0] exp_data;
        logic        exp_we;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_commit(input logic [4:0] rd, input logic [63:0] data,
                              input logic we, input logic [63:0] pc);
        chk("commit_wb_valid", 64'(wb_valid), 64'd1);
        chk("commit_we", 64'(WriteEnable), 64'(we));
        chk("commit_waddr", 64'(WriteAddr), 64'(rd));
        chk("commit_wdata", WriteData, data);
        chk("commit_pc", wb_pc, pc);
        chk("commit_stallW", 64'(stallW), 64'd0);
`ifdef WB_COMMIT_CNT_EN
        exp_cnt = exp_cnt + 64'd1;
`endif
    endtask

    task automatic drive(input vec_t v);
        u_if.m_valid   = 1'b1;
        u_if.m_is_load = v.is_load;
        u_if.m_funct3  = v.f3;
        u_if.m_addr_lo = v.alo;
        u_if.m_rd      = v.rd;
        u_if.m_rd_we   = v.rd_we;
        u_if.m_result  = v.result;
        u_if.m_pc      = v.pc;
    endtask

    // Entered and left on a falling edge.
    task automatic run_vec(input vec_t v);
        drive(v);
        @(negedge clk);
        u_if.m_valid = 1'b0;
        if (v.is_load) begin
            for (int unsigned k = 0; k < v.delay; k++) begin
                chk("wait_stallW", 64'(stallW), 64'd1);
                chk("wait_ready", 64'(u_if.m_ready), 64'd0);
                chk("wait_we", 64'(WriteEnable), 64'd0);
                if (k == v.delay - 1) begin
                    u_if.dmem_rvalid = 1'b1;
                    u_if.dmem_rdata  = v.rdata;
                end
                @(negedge clk);
            end
            u_if.dmem_rvalid = 1'b0;
            u_if.dmem_rdata  = 64'hA5A5_A5A5_A5A5_A5A5;
        end
        chk_commit(v.rd, v.exp_data, v.exp_we, v.pc);
        @(negedge clk);
        chk("idle_wb_valid", 64'(wb_valid), 64'd0);
        chk("idle_we", 64'(WriteEnable), 64'd0);
        chk("idle_wdata_hold", WriteData, v.exp_data);
        chk("idle_ready", 64'(u_if.m_ready), 64'd1);
        chk("idle_cnt", commit_cnt, exp_cnt);
    endtask

    function automatic vec_t mk(input logic ld, input logic [2:0] f3, input logic [2:0] alo,
                                input logic [63:0] rdata, input int unsigned dly,
                                input logic [4:0] rd, input logic we, input logic [63:0] res,
                                input logic [63:0] pc, input logic [63:0] ed, input logic ew);
        vec_t v;
        v.is_load = ld;  v.f3 = f3;   v.alo = alo;    v.rdata = rdata; v.delay = dly;
        v.rd = rd;       v.rd_we = we; v.result = res; v.pc = pc;
        v.exp_data = ed; v.exp_we = ew;
        return v;
    endfunction

    initial begin
        vec_t v;
        n_checks = 0;
        n_errors = 0;
        exp_cnt  = '0;

        vecs[0]  = mk(0, 3'b000, 3'd0, 64'h0, 0, 5'd5, 1, 64'h1234, 64'h8000_0000, 64'h1234, 1);
        vecs[1]  = mk(1, 3'b000, 3'd3, 64'h0000_0000_80FF_0000, 4, 5'd6, 1, 64'h0, 64'h8000_0004, 64'hFFFF_FFFF_FFFF_FF80, 1);
        vecs[2]  = mk(1, 3'b100, 3'd3, 64'h0000_0000_80FF_0000, 2, 5'd7, 1, 64'h0, 64'h8000_0008, 64'h80, 1);
        vecs[3]  = mk(1, 3'b110, 3'd4, 64'hDEAD_BEEF_0000_0000, 1, 5'd8, 1, 64'h0, 64'h8000_000C, 64'hDEAD_BEEF, 1);
        vecs[4]  = mk(1, 3'b010, 3'd4, 64'hDEAD_BEEF_0000_0000, 3, 5'd9, 1, 64'h0, 64'h8000_0010, 64'hFFFF_FFFF_DEAD_BEEF, 1);
        vecs[5]  = mk(1, 3'b001, 3'd2, 64'h0000_0000_80FF_0000, 1, 5'd10, 1, 64'h0, 64'h8000_0014, 64'hFFFF_FFFF_FFFF_80FF, 1);
        vecs[6]  = mk(1, 3'b101, 3'd2, 64'h0000_0000_80FF_0000, 2, 5'd11, 1, 64'h0, 64'h8000_0018, 64'h80FF, 1);
        vecs[7]  = mk(1, 3'b011, 3'd0, 64'h0123_4567_89AB_CDEF, 1, 5'd12, 1, 64'h0, 64'h8000_001C, 64'h0123_4567_89AB_CDEF, 1);
        vecs[8]  = mk(1, 3'b011, 3'd4, 64'h0123_4567_89AB_CDEF, 1, 5'd13, 1, 64'h0, 64'h8000_0020, 64'h0000_0000_0123_4567, 1);
        vecs[9]  = mk(1, 3'b111, 3'd0, 64'h0123_4567_89AB_CDEF, 1, 5'd14, 1, 64'h0, 64'h8000_0024, 64'h0, 1);
        vecs[10] = mk(0, 3'b000, 3'd0, 64'h0, 0, 5'd15, 0, 64'hCAFE, 64'h8000_0028, 64'hCAFE, 0);
        vecs[11] = mk(1, 3'b000, 3'd1, 64'h0000_0000_0000_7F00, 2, 5'd0, 1, 64'h0, 64'h8000_002C, 64'h7F, 0);

        // Reset held with m_valid asserted
        rst = 1'b0;
        u_if.dmem_rvalid = 1'b0;
        u_if.dmem_rdata  = 64'h0;
        drive(vecs[0]);
        repeat (3) @(negedge clk);
        chk("rst_waddr", 64'(WriteAddr), 64'd0);
        chk("rst_wdata", WriteData, 64'd0);
        chk("rst_we", 64'(WriteEnable), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_pc", wb_pc, 64'd0);
        chk("rst_cnt", commit_cnt, 64'd0);
        chk("rst_stallW", 64'(stallW), 64'd0);
        chk("rst_ready", 64'(u_if.m_ready), 64'd1);
        u_if.m_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_wb_valid", 64'(wb_valid), 64'd0);

        for (int unsigned i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back non-loads followed by an rd=0 write
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_cnt = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            v = mk(0, 3'b000, 3'd0, 64'h0, 0, (i < 4) ? 5'(i + 1) : 5'd0, 1,
                   64'h100 + 64'(i), 64'h1000 + 64'(4 * i), 64'h0, 1);
            drive(v);
            if (i > 0) begin
                chk("b2b_ready", 64'(u_if.m_ready), 64'd1);
                chk_commit(5'(i), 64'h100 + 64'(i - 1), 1'b1, 64'h1000 + 64'(4 * (i - 1)));
            end
            @(negedge clk);
        end
        u_if.m_valid = 1'b0;
        chk_commit(5'd0, 64'h104, 1'b0, 64'h1010);
        @(negedge clk);
        chk("b2b_idle_wb_valid", 64'(wb_valid), 64'd0);
`ifdef WB_COMMIT_CNT_EN
        chk("b2b_cnt", commit_cnt, 64'd5);
`else
        chk("b2b_cnt", commit_cnt, 64'd0);
`endif

        // Asynchronous reset while waiting for load data, then a stale rvalid
        v = mk(1, 3'b011, 3'd0, 64'h1111_2222_3333_4444, 1, 5'd20, 1, 64'h0, 64'h9000_0000, 64'h0, 1);
        drive(v);
        @(negedge clk);
        u_if.m_valid = 1'b0;
        chk("mid_wait_stallW", 64'(stallW), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_stallW", 64'(stallW), 64'd0);
        chk("async_rst_ready", 64'(u_if.m_ready), 64'd1);
        chk("async_rst_wdata", WriteData, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        exp_cnt = '0;
        @(negedge clk);
        u_if.dmem_rvalid = 1'b1;
        u_if.dmem_rdata  = 64'h1111_2222_3333_4444;
        @(negedge clk);
        u_if.dmem_rvalid = 1'b0;
        chk("stale_wb_valid", 64'(wb_valid), 64'd0);
        chk("stale_we", 64'(WriteEnable), 64'd0);
        chk("stale_stallW", 64'(stallW), 64'd0);
        chk("stale_ready", 64'(u_if.m_ready), 64'd1);
        @(negedge clk);
        chk("stale_wb_valid2", 64'(wb_valid), 64'd0);
        chk("stale_wdata", WriteData, 64'd0);
        chk("stale_cnt", commit_cnt, 64'd0);

        // Stage still accepts normally afterwards
        run_vec(mk(0, 3'b000, 3'd0, 64'h0, 0, 5'd3, 1, 64'hBEEF, 64'h9000_0004, 64'hBEEF, 1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage RV64 pipeline; sits directly upstream of the register file and drives its WriteAddr/WriteData/WriteEnable/stallW inputs.
- Accepts one retiring instruction at a time from the MEM stage.
- For loads, waits for the data-memory response, then aligns and sign/zero-extends the data before commit.
- Also emits a per-instruction commit pulse (wb_valid/wb_pc) for the difftest harness.

Parameters:
- XLEN, 64, datapath width (register and memory data).
- PC_W, 64, program-counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- m_valid  in  1  MEM stage presents an instruction.
- m_ready  out  1  stage can accept; high in IDLE and COMMIT, low in WAIT.
- m_pc  in  PC_W  instruction PC.
- m_rd  in  5  destination register.
- m_rd_we  in  1  instruction writes rd.
- m_result  in  XLEN  ALU/CSR result (non-load write value).
- m_is_load  in  1  instruction is a load.
- m_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
- m_addr_lo  in  3  load address bits [2:0].
- dmem_rvalid  in  1  load data valid, one-cycle pulse.
- dmem_rdata  in  XLEN  raw 8-byte-aligned memory doubleword.
- WriteAddr  out  5  regfile write index.
- WriteData  out  XLEN  regfile write data.
- WriteEnable  out  1  regfile write strobe.
- stallW  out  1  writeback stall to regfile; high exactly while in WAIT.
- wb_valid  out  1  one-cycle commit pulse.
- wb_pc  out  PC_W  PC of the committing instruction.
- commit_cnt  out  64  retired-instruction counter (see Optional Feature).

Behaviour:
- Reset (rst=0, async): state=IDLE. WriteAddr=0, WriteData=0, WriteEnable=0, wb_valid=0, wb_pc=0, commit_cnt=0, stallW=0.
- States: IDLE, WAIT, COMMIT.
- Accept condition: m_valid & m_ready.
  - Capture pc, rd, rd_we, result, funct3, addr_lo.
  - Non-load: next state COMMIT.
  - Load: next state WAIT.
- WAIT:
  - stallW=1, WriteEnable=0, m_ready=0.
  - dmem_rvalid=1 -> latch the aligned value into the data register; next state COMMIT.
  - Otherwise remain in WAIT indefinitely.
- COMMIT (exactly 1 cycle):
  - Outputs: wb_valid=1, wb_pc=pc, WriteAddr=rd, WriteData=value, WriteEnable = rd_we & (rd!=0).
  - If a new accept occurs in the same cycle -> go to COMMIT or WAIT per the new instruction (back-to-back throughput 1/cycle for non-loads); else go to IDLE.
- Outputs are registered: a non-load accepted in cycle N commits in cycle N+1. A load whose dmem_rvalid arrives in cycle K commits in cycle K+1.
- Outside COMMIT: WriteEnable=0, wb_valid=0; WriteAddr/WriteData/wb_pc hold their last values.
- Load alignment:
  - shifted = dmem_rdata >> (8*addr_lo).
  - LB/LH/LW: sign-extend bits [7:0]/[15:0]/[31:0].
  - LBU/LHU/LWU: zero-extend the same fields.
  - LD: shifted (addr_lo must be 0; a nonzero value yields the zero-filled shift, no trap).
  - funct3=111: value=0.
- rd=0 with rd_we=1: wb_valid still pulses, WriteEnable stays 0.
- dmem_rvalid outside WAIT: ignored, no state change.
- Reset mid-WAIT: return to IDLE; a later stale dmem_rvalid is ignored.

Optional Feature:
- Macro: WB_COMMIT_CNT_EN.
- Defined: commit_cnt increments by 1 on every wb_valid cycle, 64-bit, wraps from all-ones to 0, cleared by reset.
- Undefined: counter logic is absent and commit_cnt is tied to 0.

Test Plan:
- Reset: rst=0 for 3 cycles while m_valid=1 -> all outputs 0, m_ready=1. Release rst -> first commit appears 1 cycle after accept.
- ADD: rd=5, result=0x1234, pc=0x80000000, m_valid for 1 cycle -> next cycle WriteEnable=1, WriteAddr=5, WriteData=0x1234, wb_valid=1, wb_pc=0x80000000.
- LB: addr_lo=3, dmem_rdata=0x00000000_80FF0000, rvalid delayed 4 cycles -> stallW=1 and m_ready=0 for 4 cycles, then WriteData=0xFFFFFFFF_FFFFFF80. Same data with LBU -> 0x80.
- LWU addr_lo=4, rdata=0xDEADBEEF_00000000 -> 0xDEADBEEF. LW -> 0xFFFFFFFF_DEADBEEF.
- Four back-to-back non-loads, then rd=0 write -> four consecutive commit cycles; rd=0 gives wb_valid=1 with WriteEnable=0. With WB_COMMIT_CNT_EN, commit_cnt=5.
- Reset asserted in WAIT, then dmem_rvalid pulsed after release -> no commit, state IDLE, WriteEnable stays 0.
